// File: rtl/adc_acq_sequencer.sv
// Single-shot ADC trigger/capture sequencer: clear -> holdoff -> armed -> capture -> done,
// forwarding a fixed number of post-trigger samples through one AXIS output register.
//
// state   | code | meaning
// --------+------+----------------------------------------------------------
// IDLE    | 0    | trigger held in reset, waiting for cfg_start
// CLEAR   | 1    | trigger (and optionally max-sum) cleared for CLEAR_CYCLES
// HOLDOFF | 2    | trigger still held, settle for cfg_holdoff cycles
// ARMED   | 3    | trigger released, waiting for trig_active or timeout
// CAPTURE | 4    | forwarding post-trigger samples to the DMA writer
// DONE    | 5    | run finished, status valid, waiting for next cfg_start
module adc_acq_sequencer #(
    parameter int unsigned CLEAR_CYCLES = 4,
    parameter int unsigned DATA_WIDTH   = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [31:0]           cfg_post_len,
    input  logic [15:0]           cfg_holdoff,
    input  logic [31:0]           cfg_timeout,
    input  logic                  cfg_clear_max,
    input  logic                  trig_active,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  reset_trigger,
    output logic                  reset_max_sum,
    output logic [2:0]            sts_state,
    output logic                  sts_done,
    output logic                  sts_timeout,
    output logic                  sts_overflow,
    output logic [31:0]           sts_count,
    output logic [31:0]           sts_trig_cycle
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_HOLDOFF = 3'd2;
    localparam logic [2:0] ST_ARMED   = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [31:0] CLEAR_LOAD = 32'(CLEAR_CYCLES - 1);

    logic [2:0]  state, state_nxt;
    logic [31:0] timer, timer_nxt;
    logic [31:0] post_len_q, timeout_q, cycle_cnt;
    logic [15:0] holdoff_q;
    logic        clear_max_q, last_loaded;
    logic        start_ok, abort_ok, beat_done, cap_in, load, drop, load_last;
    logic [31:0] len_eff, count_inc, holdoff_load;

    assign start_ok     = cfg_start & ~cfg_abort & ((state == ST_IDLE) | (state == ST_DONE));
    assign abort_ok     = cfg_abort & (state != ST_IDLE);
    assign beat_done    = m_axis_tvalid & m_axis_tready;
    assign cap_in       = (state == ST_CAPTURE) & s_axis_tvalid & ~last_loaded;
    assign load         = cap_in & (~m_axis_tvalid | m_axis_tready);
    assign drop         = cap_in & ~load;
    assign len_eff      = (post_len_q == 32'd0) ? 32'd1 : post_len_q;
    assign count_inc    = sts_count + 32'd1;
    assign load_last    = (count_inc == len_eff);
    assign holdoff_load = (holdoff_q == 16'd0) ? 32'd0 : ({16'd0, holdoff_q} - 32'd1);
    assign sts_state    = state;

    // timer is a down-counter reloaded on every phase entry; terminal count is zero
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_nxt = ST_CLEAR;
                    timer_nxt = CLEAR_LOAD;
                end
            end
            ST_CLEAR: begin
                if (timer == 32'd0) begin
                    state_nxt = ST_HOLDOFF;
                    timer_nxt = holdoff_load;
                end else begin
                    timer_nxt = timer - 32'd1;
                end
            end
            ST_HOLDOFF: begin
                if (timer == 32'd0) begin
                    state_nxt = ST_ARMED;
                    timer_nxt = timeout_q - 32'd1;
                end else begin
                    timer_nxt = timer - 32'd1;
                end
            end
            ST_ARMED: begin
                timer_nxt = timer - 32'd1;
                if (trig_active) begin
                    state_nxt = ST_CAPTURE;
                end else if ((timeout_q != 32'd0) && (timer == 32'd0)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                if (beat_done && m_axis_tlast) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_ok) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= ST_IDLE;
            timer          <= 32'd0;
            post_len_q     <= 32'd0;
            timeout_q      <= 32'd0;
            holdoff_q      <= 16'd0;
            clear_max_q    <= 1'b0;
            cycle_cnt      <= 32'd0;
            last_loaded    <= 1'b0;
            reset_trigger  <= 1'b1;
            reset_max_sum  <= 1'b0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tlast   <= 1'b0;
            sts_done       <= 1'b0;
            sts_timeout    <= 1'b0;
            sts_overflow   <= 1'b0;
            sts_count      <= 32'd0;
            sts_trig_cycle <= 32'd0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            cycle_cnt     <= cycle_cnt + 32'd1;
            reset_trigger <= ~((state_nxt == ST_ARMED) | (state_nxt == ST_CAPTURE));
            // the latched clear_max is not yet valid on the start cycle itself
            reset_max_sum <= (state_nxt == ST_CLEAR) & (start_ok ? cfg_clear_max : clear_max_q);

            if (start_ok) begin
                post_len_q   <= cfg_post_len;
                timeout_q    <= cfg_timeout;
                holdoff_q    <= cfg_holdoff;
                clear_max_q  <= cfg_clear_max;
                last_loaded  <= 1'b0;
                sts_done     <= 1'b0;
                sts_timeout  <= 1'b0;
                sts_overflow <= 1'b0;
                sts_count    <= 32'd0;
            end

            if ((state == ST_ARMED) && (state_nxt == ST_CAPTURE)) begin
                sts_trig_cycle <= cycle_cnt;
            end
            if ((state == ST_ARMED) && (state_nxt == ST_DONE)) begin
                sts_timeout <= 1'b1;
            end
            if ((state != ST_DONE) && (state_nxt == ST_DONE)) begin
                sts_done <= 1'b1;
            end

            if (abort_ok) begin
                m_axis_tvalid <= 1'b0;
            end else if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= load_last;
                last_loaded   <= load_last;
                sts_count     <= count_inc;
            end else if (beat_done) begin
                m_axis_tvalid <= 1'b0;
            end

            if (drop && !abort_ok) begin
                sts_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed bench for adc_acq_sequencer: an acquisition-level reference model compared every
// cycle, plus literal expectations for the headline scenarios.
module tb_adc_acq_sequencer;

    localparam int CLEAR_N = 4;
    localparam int DW      = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          cfg_start, cfg_abort, cfg_clear_max;
    logic [31:0]   cfg_post_len, cfg_timeout;
    logic [15:0]   cfg_holdoff;
    logic          trig_active, s_axis_tvalid, m_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, reset_trigger, reset_max_sum;
    logic [DW-1:0] m_axis_tdata;
    logic [2:0]    sts_state;
    logic          sts_done, sts_timeout, sts_overflow;
    logic [31:0]   sts_count, sts_trig_cycle;

    always #5 aclk = ~aclk;

    adc_acq_sequencer #(.CLEAR_CYCLES(CLEAR_N), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_post_len(cfg_post_len),
        .cfg_holdoff(cfg_holdoff), .cfg_timeout(cfg_timeout), .cfg_clear_max(cfg_clear_max),
        .trig_active(trig_active), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .reset_trigger(reset_trigger),
        .reset_max_sum(reset_max_sum), .sts_state(sts_state), .sts_done(sts_done),
        .sts_timeout(sts_timeout), .sts_overflow(sts_overflow), .sts_count(sts_count),
        .sts_trig_cycle(sts_trig_cycle)
    );

    // Reference model: phase plus cycles-spent-in-phase, and an explicit count of samples
    // accepted against the requested length.
    int            m_phase, m_age, m_hold;
    logic [31:0]   m_len, m_tmo_len, m_loads, m_cyc, m_trig;
    logic          m_cm, m_ov, m_olast, m_done, m_tmo, m_ovf;
    logic [DW-1:0] m_odata;
    int            nx_phase, nx_age, nx_hold;
    logic [31:0]   nx_len, nx_tmo_len, nx_loads, nx_cyc, nx_trig;
    logic          nx_cm, nx_ov, nx_olast, nx_done, nx_tmo, nx_ovf;
    logic [DW-1:0] nx_odata;
    logic          go, ab;

    always_comb begin
        nx_phase = m_phase; nx_hold = m_hold; nx_len = m_len; nx_tmo_len = m_tmo_len;
        nx_loads = m_loads; nx_trig = m_trig; nx_cm = m_cm; nx_ov = m_ov; nx_olast = m_olast;
        nx_done = m_done; nx_tmo = m_tmo; nx_ovf = m_ovf; nx_odata = m_odata;
        nx_cyc = m_cyc + 32'd1;
        go = cfg_start && !cfg_abort && (m_phase == 0 || m_phase == 5);
        ab = cfg_abort && (m_phase != 0);
        case (m_phase)
            0, 5: if (go) nx_phase = 1;
            1: if (m_age + 1 == CLEAR_N) nx_phase = 2;
            2: if (m_age + 1 >= m_hold) nx_phase = 3;
            3: begin
                if (trig_active) begin
                    nx_phase = 4;
                    nx_trig  = m_cyc;
                end else if (m_tmo_len != 0 && 32'(m_age + 1) == m_tmo_len) begin
                    nx_phase = 5;
                    nx_tmo   = 1'b1;
                end
            end
            4: begin
                if (s_axis_tvalid && m_loads < m_len) begin
                    if (!m_ov || m_axis_tready) begin
                        nx_ov    = 1'b1;
                        nx_odata = s_axis_tdata;
                        nx_loads = m_loads + 1;
                        nx_olast = (m_loads + 1 == m_len);
                    end else begin
                        nx_ovf = 1'b1;
                    end
                end else if (m_ov && m_axis_tready) begin
                    nx_ov = 1'b0;
                end
                if (m_ov && m_axis_tready && m_olast) nx_phase = 5;
            end
            default: nx_phase = 0;
        endcase
        if (go) begin
            nx_len     = (cfg_post_len == 0) ? 32'd1 : cfg_post_len;
            nx_hold    = (cfg_holdoff == 0) ? 1 : int'(cfg_holdoff);
            nx_tmo_len = cfg_timeout;
            nx_cm      = cfg_clear_max;
            nx_done = 1'b0; nx_tmo = 1'b0; nx_ovf = 1'b0; nx_loads = 32'd0;
        end
        if (ab) begin
            nx_phase = 0;
            nx_ov    = 1'b0;
        end
        if (nx_phase == 5 && m_phase != 5) nx_done = 1'b1;
        nx_age = (nx_phase == m_phase) ? m_age + 1 : 0;
    end

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_phase <= 0; m_age <= 0; m_hold <= 1; m_len <= 32'd1; m_tmo_len <= 32'd0;
            m_loads <= 32'd0; m_cyc <= 32'd0; m_trig <= 32'd0; m_cm <= 1'b0; m_ov <= 1'b0;
            m_olast <= 1'b0; m_done <= 1'b0; m_tmo <= 1'b0; m_ovf <= 1'b0; m_odata <= '0;
        end else begin
            m_phase <= nx_phase; m_age <= nx_age; m_hold <= nx_hold; m_len <= nx_len;
            m_tmo_len <= nx_tmo_len; m_loads <= nx_loads; m_cyc <= nx_cyc; m_trig <= nx_trig;
            m_cm <= nx_cm; m_ov <= nx_ov; m_olast <= nx_olast; m_done <= nx_done;
            m_tmo <= nx_tmo; m_ovf <= nx_ovf; m_odata <= nx_odata;
        end
    end

    int errors = 0;
    int checks = 0;
    int beats = 0;
    int last_beat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("state", 32'(sts_state), 32'(m_phase));
        check("reset_trigger", 32'(reset_trigger), 32'(!(m_phase == 3 || m_phase == 4)));
        check("reset_max_sum", 32'(reset_max_sum), 32'(m_phase == 1 && m_cm));
        check("m_tvalid", 32'(m_axis_tvalid), 32'(m_ov));
        if (m_ov) begin
            check("m_tdata", 32'(m_axis_tdata), 32'(m_odata));
            check("m_tlast", 32'(m_axis_tlast), 32'(m_olast));
        end
        check("sts_done", 32'(sts_done), 32'(m_done));
        check("sts_timeout", 32'(sts_timeout), 32'(m_tmo));
        check("sts_overflow", 32'(sts_overflow), 32'(m_ovf));
        check("sts_count", sts_count, m_loads);
        check("sts_trig_cycle", sts_trig_cycle, m_trig);
    endtask

    // Entered just after a negedge, so tready/tvalid here are what the next posedge sees.
    task automatic tick();
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            beats++;
            if (m_axis_tlast) last_beat = beats;
        end
        @(negedge aclk);
        if (aresetn) compare_all();
        #1;
        s_axis_tdata = s_axis_tdata + 16'd1;
    endtask

    task automatic wait_state(input logic [2:0] code, input int max_cycles);
        int n = 0;
        while (sts_state != code && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_state", 32'(sts_state), 32'(code));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, n, m, rms_hi;
        logic [DW-1:0] exp_first;
        aresetn = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_clear_max = 1'b0;
        cfg_post_len = 32'd1; cfg_timeout = 32'd0; cfg_holdoff = 16'd0;
        trig_active = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 16'h1000; m_axis_tready = 1'b1;
        repeat (3) tick();
        check("rst_state", 32'(sts_state), 32'd0);
        check("rst_reset_trigger", 32'(reset_trigger), 32'd1);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        aresetn = 1'b1;
        tick();

        // post_len=5, trigger at cycle 20; cfg change after start must not matter
        cfg_post_len = 32'd5; cfg_holdoff = 16'd3; cfg_timeout = 32'd0; cfg_clear_max = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_post_len = 32'd2;
        n = 0;
        while (m_cyc != 32'd20 && n < 50) begin
            tick();
            n++;
        end
        b0 = beats;
        trig_active = 1'b1; s_axis_tvalid = 1'b1;
        tick();
        trig_active = 1'b0;
        wait_state(3'd5, 60);
        s_axis_tvalid = 1'b0;
        check("a_beats", 32'(beats - b0), 32'd5);
        check("a_tlast_beat", 32'(last_beat - b0), 32'd5);
        check("a_count", sts_count, 32'd5);
        check("a_done", 32'(sts_done), 32'd1);
        check("a_trig_cycle", sts_trig_cycle, 32'd20);

        // clear_max=1, holdoff=3, timeout=10, no trigger
        cfg_clear_max = 1'b1; cfg_holdoff = 16'd3; cfg_timeout = 32'd10; cfg_post_len = 32'd5;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n = 0; rms_hi = 0;
        while (reset_trigger && n < 50) begin
            rms_hi += int'(reset_max_sum);
            tick();
            n++;
        end
        check("b_rt_low_delay", 32'(n), 32'd7);
        check("b_rms_high_cycles", 32'(rms_hi), 32'd4);
        m = 0;
        while (sts_state != 3'd5 && m < 50) begin
            tick();
            m++;
        end
        check("b_timeout_delay", 32'(m), 32'd10);
        check("b_timeout", 32'(sts_timeout), 32'd1);
        check("b_count", sts_count, 32'd0);
        check("b_done", 32'(sts_done), 32'd1);

        // post_len=4 with tready low for 3 capture cycles
        cfg_clear_max = 1'b0; cfg_holdoff = 16'd0; cfg_timeout = 32'd0; cfg_post_len = 32'd4;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        wait_state(3'd3, 30);
        b0 = beats;
        trig_active = 1'b1; s_axis_tvalid = 1'b1;
        tick();
        trig_active = 1'b0; m_axis_tready = 1'b0;
        exp_first = s_axis_tdata;
        repeat (3) tick();
        check("c_tdata_held", 32'(m_axis_tdata), 32'(exp_first));
        check("c_tvalid_stalled", 32'(m_axis_tvalid), 32'd1);
        m_axis_tready = 1'b1;
        wait_state(3'd5, 30);
        s_axis_tvalid = 1'b0;
        check("c_beats", 32'(beats - b0), 32'd4);
        check("c_overflow", 32'(sts_overflow), 32'd1);
        check("c_count", sts_count, 32'd4);
        check("c_done", 32'(sts_done), 32'd1);

        // abort together with start while armed
        cfg_holdoff = 16'd2;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        wait_state(3'd3, 30);
        cfg_abort = 1'b1; cfg_start = 1'b1;
        tick();
        cfg_abort = 1'b0; cfg_start = 1'b0;
        check("d_state", 32'(sts_state), 32'd0);
        check("d_reset_trigger", 32'(reset_trigger), 32'd1);
        check("d_done", 32'(sts_done), 32'd0);
        tick();

        // reset in the middle of a stalled capture
        cfg_post_len = 32'd8;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        wait_state(3'd3, 30);
        trig_active = 1'b1; s_axis_tvalid = 1'b1;
        tick();
        trig_active = 1'b0; m_axis_tready = 1'b0;
        repeat (3) tick();
        check("e_tvalid_before", 32'(m_axis_tvalid), 32'd1);
        check("e_overflow_before", 32'(sts_overflow), 32'd1);
        aresetn = 1'b0;
        #1;
        check("e_state", 32'(sts_state), 32'd0);
        check("e_reset_trigger", 32'(reset_trigger), 32'd1);
        check("e_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("e_overflow", 32'(sts_overflow), 32'd0);
        check("e_count", sts_count, 32'd0);
        check("e_trig_cycle", sts_trig_cycle, 32'd0);
        repeat (2) tick();
        aresetn = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
